signed_mac_accumulator: RTL and testbench

SIGNED_MAC_ACCUMULATOR -- requirements
Module: signed_mac_accumulator

---
 rtl/signed_mac_accumulator_if.sv | 30 +++
 rtl/signed_mac_accumulator.sv | 195 +++++++++++++++++++
 tb/tb_signed_mac_accumulator.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/signed_mac_accumulator_if.sv
// Purpose: sample-in / frame-result-out bundle for the signed MAC accumulator.
// Latency: none (wires only).
// Backpressure: in_valid/in_ready on the sample side, out_valid/out_ready on the result side.
interface signed_mac_accumulator_if #(
    parameter int A_SIZE   = 8,
    parameter int B_SIZE   = 8,
    parameter int ACC_SIZE = 16
);
    logic                       in_valid;
    logic                       in_ready;
    logic                       in_last;
    logic signed [A_SIZE-1:0]   a;
    logic signed [B_SIZE-1:0]   b;
    logic                       out_valid;
    logic                       out_ready;
    logic signed [ACC_SIZE-1:0] out;
    logic                       out_sat;

    // Producer of samples and consumer of results.
    modport master (
        output in_valid, in_last, a, b, out_ready,
        input  in_ready, out_valid, out, out_sat
    );

    // The accumulator itself.
    modport slave (
        input  in_valid, in_last, a, b, out_ready,
        output in_ready, out_valid, out, out_sat
    );
endinterface

// File: rtl/signed_mac_accumulator.sv
// Purpose: per-frame saturating sum of (a*b)>>>OFFSET terms with a sticky saturation flag.
// Latency: result valid two edges after the edge that accepts the last sample.
// Backpressure: in_ready drops from the last accept until the held result is taken by out_ready.
module signed_mac_accumulator #(
    parameter int A_SIZE   = 8,
    parameter int B_SIZE   = 8,
    parameter int OFFSET   = 0,
    parameter int ACC_SIZE = 16
) (
    input logic                    clk,
    input logic                    rst,
    signed_mac_accumulator_if.slave bus
);
    // Product width and a working width wide enough to hold either the product or the
    // accumulator range plus a sign guard bit, so clamp comparisons never overflow.
    localparam int PW = A_SIZE + B_SIZE;
    localparam int WW = ((PW > ACC_SIZE) ? PW : ACC_SIZE) + 1;

    localparam logic signed [WW-1:0] TERM_MAX = {{(WW-ACC_SIZE+1){1'b0}}, {(ACC_SIZE-1){1'b1}}};
    localparam logic signed [WW-1:0] TERM_MIN = {{(WW-ACC_SIZE+1){1'b1}}, {(ACC_SIZE-1){1'b0}}};
    localparam logic [ACC_SIZE-1:0]  ACC_MAX  = {1'b0, {(ACC_SIZE-1){1'b1}}};
    localparam logic [ACC_SIZE-1:0]  ACC_MIN  = {1'b1, {(ACC_SIZE-1){1'b0}}};

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        HOLD  = 2'd2
    } state_t;

    // Stage-1 payload: clamped term plus its control bits.
    typedef struct packed {
        logic                vld;
        logic                last;
        logic                tsat;
        logic [ACC_SIZE-1:0] term;
    } s1_t;

    state_t state, state_nxt;
    logic   in_ready_c;
    logic   out_valid_c;
    logic   accept;

    // Stage 0: registered operands
    logic                     s0_vld;
    logic                     s0_last;
    logic signed [A_SIZE-1:0] s0_a;
    logic signed [B_SIZE-1:0] s0_b;

    // Stage 1 combinational product / shift / clamp
    logic signed [PW-1:0]     a_ext;
    logic signed [PW-1:0]     b_ext;
    logic signed [PW-1:0]     prod;
    logic signed [PW-1:0]     prod_sh;
    logic signed [WW-1:0]     term_w;
    logic [ACC_SIZE-1:0]      term_c;
    logic                     tsat_c;
    s1_t                      s1;

    // Stage 2 accumulator
    logic signed [ACC_SIZE-1:0] acc;
    logic                       flag;
    logic [ACC_SIZE:0]          sum_w;
    logic [ACC_SIZE-1:0]        sum_c;
    logic                       asat_c;
    logic                       frame_sat_c;
    logic signed [ACC_SIZE-1:0] out_r;
    logic                       out_sat_r;

    // Only RUN takes samples, so acceptance follows directly from the state.
    assign accept = bus.in_valid && (state == RUN);

    // Capture the operands of an accepted sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            s0_vld  <= 1'b0;
            s0_last <= 1'b0;
            s0_a    <= '0;
            s0_b    <= '0;
        end else begin
            s0_vld  <= accept;
            s0_last <= accept && bus.in_last;
            if (accept) begin
                s0_a <= bus.a;
                s0_b <= bus.b;
            end
        end
    end

    // Full-precision product, arithmetic shift, clamp into the accumulator range.
    always_comb begin
        a_ext   = {{B_SIZE{s0_a[A_SIZE-1]}}, s0_a};
        b_ext   = {{A_SIZE{s0_b[B_SIZE-1]}}, s0_b};
        prod    = a_ext * b_ext;
        prod_sh = prod >>> OFFSET;
        term_w  = {{(WW-PW){prod_sh[PW-1]}}, prod_sh};
        term_c  = term_w[ACC_SIZE-1:0];
        tsat_c  = 1'b0;
        if (term_w > TERM_MAX) begin
            term_c = ACC_MAX;
            tsat_c = 1'b1;
        end else if (term_w < TERM_MIN) begin
            term_c = ACC_MIN;
            tsat_c = 1'b1;
        end
    end

    // Register the clamped term and its valid/last/clamp bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= '0;
        end else begin
            s1.vld  <= s0_vld;
            s1.last <= s0_last;
            s1.tsat <= s0_vld && tsat_c;
            s1.term <= term_c;
        end
    end

    // One guard bit detects overflow of acc+term; clamp toward the overflow direction.
    always_comb begin
        sum_w  = {acc[ACC_SIZE-1], acc} + {s1.term[ACC_SIZE-1], s1.term};
        sum_c  = sum_w[ACC_SIZE-1:0];
        asat_c = 1'b0;
        if (sum_w[ACC_SIZE] != sum_w[ACC_SIZE-1]) begin
            asat_c = 1'b1;
            sum_c  = sum_w[ACC_SIZE] ? ACC_MIN : ACC_MAX;
        end
        frame_sat_c = flag | s1.tsat | asat_c;
    end

    // Accumulate; on the last term publish the result and restart from zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc       <= '0;
            flag      <= 1'b0;
            out_r     <= '0;
            out_sat_r <= 1'b0;
        end else if (s1.vld) begin
            if (s1.last) begin
                out_r     <= sum_c;
                out_sat_r <= frame_sat_c;
                acc       <= '0;
                flag      <= 1'b0;
            end else begin
                acc  <= sum_c;
                flag <= frame_sat_c;
            end
        end
    end

    // Frame-control state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and handshake outputs: RUN takes samples, DRAIN waits out the
    // pipeline, HOLD presents the result until it is consumed.
    always_comb begin
        state_nxt   = state;
        in_ready_c  = 1'b0;
        out_valid_c = 1'b0;
        case (state)
            RUN: begin
                in_ready_c = 1'b1;
                if (bus.in_valid && bus.in_last) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (s1.vld && s1.last) begin
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                out_valid_c = 1'b1;
                if (bus.out_ready) begin
                    state_nxt = RUN;
                end
            end
            default: begin
                state_nxt = RUN;
            end
        endcase
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_c;
    assign bus.out       = out_r;
    assign bus.out_sat   = out_sat_r;

endmodule

// File: tb/tb_signed_mac_accumulator.sv
// Purpose: randomized and directed checks of the signed MAC accumulator against a behavioural model.
// Latency: n/a (bench).
// Backpressure: exercises held results with out_ready low and ignored in_valid pulses.
module tb_signed_mac_accumulator;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    signed_mac_accumulator_if #(.A_SIZE(8), .B_SIZE(8), .ACC_SIZE(16)) bus0 ();
    signed_mac_accumulator_if #(.A_SIZE(8), .B_SIZE(8), .ACC_SIZE(16)) bus1 ();
    signed_mac_accumulator_if #(.A_SIZE(8), .B_SIZE(8), .ACC_SIZE(8))  bus2 ();

    signed_mac_accumulator #(.A_SIZE(8), .B_SIZE(8), .OFFSET(0), .ACC_SIZE(16)) dut0 (
        .clk(clk), .rst(rst), .bus(bus0));
    signed_mac_accumulator #(.A_SIZE(8), .B_SIZE(8), .OFFSET(4), .ACC_SIZE(16)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1));
    signed_mac_accumulator #(.A_SIZE(8), .B_SIZE(8), .OFFSET(0), .ACC_SIZE(8)) dut2 (
        .clk(clk), .rst(rst), .bus(bus2));

    int total = 0;
    int bad   = 0;

    // Model state for the default instance.
    int m_acc   = 0;
    bit m_sat   = 1'b0;
    int exp_out = 0;
    bit exp_sat = 1'b0;

    function automatic int sat_to(input longint v, input int w, output bit s);
        longint hi = (longint'(1) <<< (w - 1)) - 1;
        longint lo = -hi - 1;
        s = 1'b0;
        if (v > hi) begin s = 1'b1; return int'(hi); end
        if (v < lo) begin s = 1'b1; return int'(lo); end
        return int'(v);
    endfunction

    // One MAC term: clamp((a*b)>>>off), then clamp(acc+term).
    function automatic void mac_step(input int acc_in, input int a, input int b, input int off,
                                     input int w, output int acc_out, output bit sat);
        bit s1, s2;
        int term;
        term    = sat_to((longint'(a) * longint'(b)) >>> off, w, s1);
        acc_out = sat_to(longint'(acc_in) + longint'(term), w, s2);
        sat     = s1 | s2;
    endfunction

    function automatic void model_push(input int a, input int b, input bit last);
        int nacc;
        bit s;
        mac_step(m_acc, a, b, 0, 16, nacc, s);
        m_sat = m_sat | s;
        if (last) begin
            exp_out = nacc;
            exp_sat = m_sat;
            m_acc   = 0;
            m_sat   = 1'b0;
        end else begin
            m_acc = nacc;
        end
    endfunction

    task automatic send0(input int a, input int b, input bit last);
        int n = 0;
        bus0.a        = a[7:0];
        bus0.b        = b[7:0];
        bus0.in_last  = last;
        bus0.in_valid = 1'b1;
        while (bus0.in_ready !== 1'b1 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 100) begin
            total++; bad++;
            $display("FAIL send_wait: in_ready never rose");
        end
        @(posedge clk); #1;
        bus0.in_valid = 1'b0;
        bus0.in_last  = 1'b0;
        model_push(a, b, last);
    endtask

    task automatic wait_valid0(input string name);
        int n = 0;
        while (bus0.out_valid !== 1'b1 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 50) begin
            total++; bad++;
            $display("FAIL %s_timeout: out_valid never rose", name);
        end
    endtask

    task automatic get_result0(input string name, input int delay);
        logic signed [15:0] e;
        e = exp_out[15:0];
        wait_valid0(name);
        repeat (delay) begin @(posedge clk); #1; end
        total++;
        if (bus0.out !== e) begin
            bad++; $display("FAIL %s_out: got %0d want %0d", name, bus0.out, e);
        end
        total++;
        if (bus0.out_sat !== exp_sat) begin
            bad++; $display("FAIL %s_sat: got %b want %b", name, bus0.out_sat, exp_sat);
        end
        bus0.out_ready = 1'b1;
        @(posedge clk); #1;
        bus0.out_ready = 1'b0;
        total++;
        if (bus0.out_valid !== 1'b0 || bus0.in_ready !== 1'b1) begin
            bad++; $display("FAIL %s_release: out_valid=%b in_ready=%b want 0/1",
                            name, bus0.out_valid, bus0.in_ready);
        end
        total++;
        if (bus0.out !== e || bus0.out_sat !== exp_sat) begin
            bad++; $display("FAIL %s_retain: got %0d/%b want %0d/%b",
                            name, bus0.out, bus0.out_sat, e, exp_sat);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst   = 1'b0;
        m_acc = 0;
        m_sat = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if (bus0.in_ready !== 1'b1) begin
            bad++; $display("FAIL reset_in_ready: got %b want 1", bus0.in_ready);
        end
        total++;
        if (bus0.out_valid !== 1'b0) begin
            bad++; $display("FAIL reset_out_valid: got %b want 0", bus0.out_valid);
        end
        total++;
        if (bus0.out !== 16'sd0 || bus0.out_sat !== 1'b0) begin
            bad++; $display("FAIL reset_out: got %0d/%b want 0/0", bus0.out, bus0.out_sat);
        end
        total++;
        if (bus1.out_valid !== 1'b0 || bus2.out_valid !== 1'b0 || bus2.out !== 8'sd0) begin
            bad++; $display("FAIL reset_others: valids %b %b out2 %0d want 0 0 0",
                            bus1.out_valid, bus2.out_valid, bus2.out);
        end
    endtask

    task automatic test_basic_latency();
        send0(3, 4, 1'b0);
        send0(-2, 5, 1'b0);
        send0(7, -1, 1'b1);
        total++;
        if (bus0.in_ready !== 1'b0 || bus0.out_valid !== 1'b0) begin
            bad++; $display("FAIL lat_edge0: in_ready=%b out_valid=%b want 0/0",
                            bus0.in_ready, bus0.out_valid);
        end
        @(posedge clk); #1;
        total++;
        if (bus0.in_ready !== 1'b0 || bus0.out_valid !== 1'b0) begin
            bad++; $display("FAIL lat_edge1: in_ready=%b out_valid=%b want 0/0",
                            bus0.in_ready, bus0.out_valid);
        end
        @(posedge clk); #1;
        total++;
        if (bus0.out_valid !== 1'b1) begin
            bad++; $display("FAIL lat_edge2: out_valid=%b want 1", bus0.out_valid);
        end
        get_result0("basic", 0);
    endtask

    task automatic test_saturate();
        send0(-128, -128, 1'b0);
        send0(-128, -128, 1'b0);
        send0(-128, 127, 1'b1);
        get_result0("acc_clamp", 1);
    endtask

    task automatic test_hold();
        logic signed [15:0] e;
        send0(1, 2, 1'b1);
        e = exp_out[15:0];
        wait_valid0("hold");
        for (int i = 0; i < 5; i++) begin
            bus0.in_valid = (i % 2 == 0);
            bus0.in_last  = 1'b1;
            bus0.a        = 8'($urandom_range(0, 255));
            bus0.b        = 8'($urandom_range(0, 255));
            @(posedge clk); #1;
            total++;
            if (bus0.out !== e || bus0.out_valid !== 1'b1 || bus0.in_ready !== 1'b0) begin
                bad++; $display("FAIL hold_cycle%0d: out=%0d valid=%b ready=%b want %0d/1/0",
                                i, bus0.out, bus0.out_valid, bus0.in_ready, e);
            end
        end
        bus0.in_valid = 1'b0;
        bus0.in_last  = 1'b0;
        get_result0("hold", 0);
        send0(2, 3, 1'b1);
        get_result0("after_hold", 0);
    endtask

    task automatic test_reset_mid();
        send0(5, 5, 1'b0);
        send0(5, 5, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst   = 1'b0;
        m_acc = 0;
        m_sat = 1'b0;
        send0(1, 1, 1'b1);
        get_result0("rst_mid", 0);
        send0(100, 100, 1'b1);
        wait_valid0("rst_hold");
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        total++;
        if (bus0.out_valid !== 1'b0 || bus0.out !== 16'sd0 || bus0.out_sat !== 1'b0
            || bus0.in_ready !== 1'b1) begin
            bad++; $display("FAIL rst_hold: valid=%b out=%0d sat=%b ready=%b want 0/0/0/1",
                            bus0.out_valid, bus0.out, bus0.out_sat, bus0.in_ready);
        end
    endtask

    task automatic test_single();
        send0(-8, -8, 1'b1);
        get_result0("single", 0);
        send0(0, 0, 1'b1);
        get_result0("zero", 0);
    endtask

    task automatic test_random();
        for (int f = 0; f < 12; f++) begin
            int len = int'($urandom_range(1, 5));
            for (int k = 0; k < len; k++) begin
                int a = int'($urandom_range(0, 255)) - 128;
                int b = int'($urandom_range(0, 255)) - 128;
                if ($urandom_range(0, 3) == 0) begin
                    repeat ($urandom_range(1, 2)) begin @(posedge clk); #1; end
                end
                send0(a, b, k == len - 1);
            end
            get_result0("random", int'($urandom_range(0, 3)));
        end
    endtask

    task automatic test_params();
        int e1, e2, n;
        bit s1, s2;
        mac_step(0, -128, 127, 4, 16, e1, s1);
        mac_step(0, 16, 16, 0, 8, e2, s2);
        bus1.a = 8'sh80; bus1.b = 8'sd127; bus1.in_last = 1'b1; bus1.in_valid = 1'b1;
        bus2.a = 8'sd16; bus2.b = 8'sd16;  bus2.in_last = 1'b1; bus2.in_valid = 1'b1;
        @(posedge clk); #1;
        bus1.in_valid = 1'b0; bus2.in_valid = 1'b0;
        n = 0;
        while ((bus1.out_valid !== 1'b1 || bus2.out_valid !== 1'b1) && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 50) begin
            total++; bad++;
            $display("FAIL params_timeout: out_valid %b %b", bus1.out_valid, bus2.out_valid);
        end
        total++;
        if (bus1.out !== 16'(e1) || bus1.out_sat !== s1) begin
            bad++; $display("FAIL offset4: got %0d/%b want %0d/%b", bus1.out, bus1.out_sat, e1, s1);
        end
        total++;
        if (bus2.out !== 8'(e2) || bus2.out_sat !== s2) begin
            bad++; $display("FAIL acc8: got %0d/%b want %0d/%b", bus2.out, bus2.out_sat, e2, s2);
        end
    endtask

    initial begin
        rst = 1'b1;
        bus0.in_valid = 1'b0; bus0.in_last = 1'b0; bus0.a = '0; bus0.b = '0; bus0.out_ready = 1'b0;
        bus1.in_valid = 1'b0; bus1.in_last = 1'b0; bus1.a = '0; bus1.b = '0; bus1.out_ready = 1'b0;
        bus2.in_valid = 1'b0; bus2.in_last = 1'b0; bus2.a = '0; bus2.b = '0; bus2.out_ready = 1'b0;
        test_reset();
        test_basic_latency();
        test_saturate();
        test_hold();
        test_reset_mid();
        test_single();
        test_random();
        test_params();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
